// File: rtl/fu_issue_scheduler_pkg.sv
// Shared parameters, types and helpers for the issue-stage scheduler slice.
// Imported by the interface, the age selector and the scheduler top.
package fu_issue_scheduler_pkg;

   localparam int N_RS     = 8;
   localparam int N_WAY    = 2;
   localparam int N_MULT   = 1;
   localparam int MULT_LAT = 4;
   localparam int CDB_BITS = 6;

   localparam int IW = $clog2(N_RS) + 1;
   localparam int CW = $clog2(N_WAY) + 1;
   localparam int RW = $clog2(N_RS);
   localparam int FW = $clog2(N_WAY);

   typedef logic [RW-1:0]       rs_idx_t;
   typedef logic [FW-1:0]       fu_id_t;
   typedef logic [CW-1:0]       cnt_t;
   typedef logic [CW:0]         sum_t;
   typedef logic [CDB_BITS-1:0] tag_t;

   typedef logic [N_RS-1:0][IW-1:0]       order_vec_t;
   typedef logic [N_RS-1:0][CDB_BITS-1:0] tag_vec_t;
   typedef logic [MULT_LAT-1:0][CW-1:0]   wb_table_t;

   typedef enum logic {FU_ALU, FU_MULT} fu_type_e;

   typedef struct packed {
      logic     valid;
      rs_idx_t  rs_idx;
      fu_type_e fu_type;
      fu_id_t   fu_id;
      tag_t     dest_tag;
   } issue_grant_t;

   // A booking table is legal only if no future cycle owes more than N_WAY CDB writes.
   function automatic logic table_in_range(wb_table_t tbl);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MULT_LAT; i++) begin
         if (tbl[i] > cnt_t'(N_WAY)) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/fu_issue_scheduler_if.sv
// Request/grant bundle between the reservation station (master) and the
// issue scheduler (slave), including the issue packets toward execute.
interface fu_issue_scheduler_if;
   import fu_issue_scheduler_pkg::*;

   logic                      ex_stall;
   logic [N_RS-1:0]           req_valid;
   logic [N_RS-1:0]           req_is_mult;
   order_vec_t                req_order;
   tag_vec_t                  req_dest_tag;
   logic [N_RS-1:0]           grant;
   cnt_t                      issue_num;
   issue_grant_t [N_WAY-1:0]  issue_packet;
   wb_table_t                 wb_resv;

   modport master (
      output ex_stall, req_valid, req_is_mult, req_order, req_dest_tag,
      input  grant, issue_num, issue_packet, wb_resv
   );

   modport slave (
      input  ex_stall, req_valid, req_is_mult, req_order, req_dest_tag,
      output grant, issue_num, issue_packet, wb_resv
   );

endinterface

// File: rtl/fu_issue_scheduler_age_priority_select.sv
// Combinational age sorter: lists eligible RS entries oldest first,
// breaking order ties toward the lower RS index.
module age_priority_select
   import fu_issue_scheduler_pkg::*;
(
   input  order_vec_t            order,
   input  logic [N_RS-1:0]       eligible,
   output rs_idx_t [N_RS-1:0]    sorted_idx,
   output logic [N_RS-1:0]       sorted_valid
);

   rs_idx_t rank;

   // Each eligible entry lands at the position equal to the count of entries that beat it.
   always_comb begin
      sorted_idx   = '0;
      sorted_valid = '0;
      rank         = '0;
      for (int i = 0; i < N_RS; i++) begin
         rank = '0;
         if (eligible[i]) begin
            for (int j = 0; j < N_RS; j++) begin
               if (eligible[j] && ((order[j] < order[i]) || ((order[j] == order[i]) && (j < i)))) begin
                  rank = rank + rs_idx_t'(1);
               end
            end
            sorted_idx[rank]   = rs_idx_t'(i);
            sorted_valid[rank] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler: picks up to N_WAY ready entries oldest first, binds them to
// ALUs or multipliers, and books future CDB slots so writeback never exceeds N_WAY.
module fu_issue_scheduler
   import fu_issue_scheduler_pkg::*;
(
   input logic                 clock,
   input logic                 reset,
   fu_issue_scheduler_if.slave bus
);

   logic                     active;
   logic [N_RS-1:0]          eligible;
   rs_idx_t [N_RS-1:0]       sorted_idx;
   logic [N_RS-1:0]          sorted_valid;
   wb_table_t                wb_q;
   wb_table_t                wb_next;
   logic [N_RS-1:0]          grant;
   issue_grant_t [N_WAY-1:0] packet;
   sum_t                     n_grant;
   sum_t                     alu_cnt;
   sum_t                     mult_cnt;
   rs_idx_t                  idx;
   logic                     take;
   fu_type_e                 take_type;
   sum_t                     take_unit;
   logic [N_RS-1:0]          order_zero;

   function automatic issue_grant_t make_packet(rs_idx_t rs, fu_type_e ft, sum_t unit, tag_t tag);
      issue_grant_t g;
      g.valid    = 1'b1;
      g.rs_idx   = rs;
      g.fu_type  = ft;
      g.fu_id    = fu_id_t'(unit);
      g.dest_tag = tag;
      return g;
   endfunction

   assign active   = reset && !bus.ex_stall;
   assign eligible = bus.req_valid & {N_RS{active}};

   age_priority_select u_select (
      .order        (bus.req_order),
      .eligible     (eligible),
      .sorted_idx   (sorted_idx),
      .sorted_valid (sorted_valid)
   );

   // Walk candidates oldest first; a blocked entry is skipped so younger ones can still issue.
   always_comb begin
      grant     = '0;
      packet    = '0;
      n_grant   = '0;
      alu_cnt   = '0;
      mult_cnt  = '0;
      idx       = '0;
      take      = 1'b0;
      take_type = FU_ALU;
      take_unit = '0;
      for (int p = 0; p < N_RS; p++) begin
         idx       = sorted_idx[p];
         take      = 1'b0;
         take_type = FU_ALU;
         take_unit = alu_cnt;
         if (sorted_valid[p] && (n_grant < sum_t'(N_WAY))) begin
            if (!bus.req_is_mult[idx]) begin
               take = (sum_t'(wb_q[0]) + alu_cnt) < sum_t'(N_WAY);
            end else begin
               take_type = FU_MULT;
               take_unit = mult_cnt;
               take = (mult_cnt < sum_t'(N_MULT)) &&
                      ((sum_t'(wb_q[MULT_LAT-1]) + mult_cnt) < sum_t'(N_WAY));
            end
         end
         if (take) begin
            grant[idx] = 1'b1;
            for (int k = 0; k < N_WAY; k++) begin
               if (sum_t'(k) == n_grant) begin
                  packet[k] = make_packet(idx, take_type, take_unit, bus.req_dest_tag[idx]);
               end
            end
            n_grant = n_grant + sum_t'(1);
            if (take_type == FU_MULT) mult_cnt = mult_cnt + sum_t'(1);
            else                      alu_cnt  = alu_cnt + sum_t'(1);
         end
      end
   end

   // ALU results are checked against slot 0 but never stored; only multiplier bookings persist.
   always_comb begin
      wb_next = wb_q;
      if (!bus.ex_stall) begin
         for (int i = 0; i < MULT_LAT-1; i++) begin
            wb_next[i] = wb_q[i+1];
         end
         wb_next[MULT_LAT-1] = '0;
         wb_next[MULT_LAT-2] = wb_next[MULT_LAT-2] + cnt_t'(mult_cnt);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) wb_q <= '0;
      else        wb_q <= wb_next;
   end

   assign bus.grant        = grant;
   assign bus.issue_num    = cnt_t'(n_grant);
   assign bus.issue_packet = packet;
   assign bus.wb_resv      = wb_q;

   always_comb begin
      order_zero = '0;
      for (int i = 0; i < N_RS; i++) begin
         order_zero[i] = (bus.req_order[i] == '0);
      end
   end

   ap_table_range: assert property (@(posedge clock) disable iff (!reset) table_in_range(wb_next));
   ap_order_legal: assert property (@(posedge clock) disable iff (!reset) ((bus.req_valid & order_zero) == '0));

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Randomized scoreboard bench for fu_issue_scheduler: a calendar-based model of
// CDB writes per logical cycle predicts grants, packets and the booking table.
module tb_fu_issue_scheduler;
   import fu_issue_scheduler_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   fu_issue_scheduler_if bus ();

   fu_issue_scheduler dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [N_RS-1:0]          grant;
      cnt_t                     issue_num;
      issue_grant_t [N_WAY-1:0] packet;
      wb_table_t                wb;
   } expect_t;

   expect_t exp_q[$];
   int      compared   = 0;
   int      mismatched = 0;
   int      mult_book[256];
   int      lt = 0;

   function automatic void model_reset();
      for (int i = 0; i < 256; i++) mult_book[i] = 0;
      lt = 0;
   endfunction

   // Time in the model advances only on edges that are neither stalled nor in reset.
   function automatic void model_edge();
      if (reset === 1'b1 && bus.ex_stall === 1'b0) begin
         mult_book[lt % 256] = 0;
         lt = lt + 1;
      end
   endfunction

   function automatic expect_t model_cycle();
      expect_t e;
      bit      done[N_RS];
      int      granted, alu_used, mult_used, best, unit;
      logic    is_mult;
      e.grant     = '0;
      e.issue_num = '0;
      e.packet    = '0;
      for (int i = 0; i < MULT_LAT; i++) e.wb[i] = cnt_t'(mult_book[(lt + i + 1) % 256]);
      granted = 0; alu_used = 0; mult_used = 0;
      for (int i = 0; i < N_RS; i++) done[i] = 1'b0;
      if (reset === 1'b1 && bus.ex_stall === 1'b0) begin
         for (int pass = 0; pass < N_RS; pass++) begin
            best = -1;
            for (int i = 0; i < N_RS; i++) begin
               if (bus.req_valid[i] && !done[i] && (best < 0 || bus.req_order[i] < bus.req_order[best])) best = i;
            end
            if (best < 0 || granted == N_WAY) break;
            done[best] = 1'b1;
            is_mult = bus.req_is_mult[best];
            unit = -1;
            if (!is_mult) begin
               if (mult_book[(lt + 1) % 256] + alu_used < N_WAY) begin
                  unit = alu_used;
                  alu_used++;
               end
            end else if (mult_used < N_MULT && mult_book[(lt + MULT_LAT) % 256] < N_WAY) begin
               unit = mult_used;
               mult_used++;
               mult_book[(lt + MULT_LAT) % 256]++;
            end
            if (unit >= 0) begin
               e.grant[best] = 1'b1;
               e.packet[granted].valid    = 1'b1;
               e.packet[granted].rs_idx   = rs_idx_t'(best);
               e.packet[granted].fu_type  = is_mult ? FU_MULT : FU_ALU;
               e.packet[granted].fu_id    = fu_id_t'(unit);
               e.packet[granted].dest_tag = bus.req_dest_tag[best];
               granted++;
            end
         end
      end
      e.issue_num = cnt_t'(granted);
      return e;
   endfunction

   function automatic order_vec_t rand_orders();
      order_vec_t o;
      for (int i = 0; i < N_RS; i++) o[i] = IW'($urandom_range(1, (1 << IW) - 1));
      return o;
   endfunction

   function automatic order_vec_t flat_orders(int v);
      order_vec_t o;
      for (int i = 0; i < N_RS; i++) o[i] = IW'(v);
      return o;
   endfunction

   function automatic void drive(logic [N_RS-1:0] valid, logic [N_RS-1:0] mult, order_vec_t ord, logic stall);
      bus.req_valid   = valid;
      bus.req_is_mult = mult;
      bus.req_order   = ord;
      bus.ex_stall    = stall;
      for (int i = 0; i < N_RS; i++) bus.req_dest_tag[i] = CDB_BITS'($urandom);
   endfunction

   task automatic apply_stimulus(input logic [N_RS-1:0] valid, input logic [N_RS-1:0] mult,
                                 input order_vec_t ord, input logic stall);
      @(posedge clock);
      model_edge();
      #1;
      reset = 1'b1;
      drive(valid, mult, ord, stall);
      exp_q.push_back(model_cycle());
   endtask

   task automatic hold_reset(input logic [N_RS-1:0] valid, input order_vec_t ord, input logic stall);
      @(posedge clock);
      model_edge();
      #1;
      reset = 1'b0;
      drive(valid, '0, ord, stall);
      model_reset();
      exp_q.push_back(model_cycle());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus('0, '0, flat_orders(1), 1'b0);
   endtask

   function automatic void cmp(string name, logic [63:0] got, logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endfunction

   task automatic check_output(input expect_t e);
      cmp("grant",        64'(bus.grant),        64'(e.grant));
      cmp("issue_num",    64'(bus.issue_num),    64'(e.issue_num));
      cmp("issue_packet", 64'(bus.issue_packet), 64'(e.packet));
      cmp("wb_resv",      64'(bus.wb_resv),      64'(e.wb));
   endtask

   // Monitor: independent of stimulus, pops one expectation per presented cycle.
   initial begin
      expect_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin
      order_vec_t o;
      int         drain;
      model_reset();
      drive('1, '0, flat_orders(3), 1'b0);

      hold_reset('1, flat_orders(3), 1'b0);
      hold_reset('1, flat_orders(3), 1'b0);
      apply_stimulus('1, '0, flat_orders(3), 1'b0);
      idle(MULT_LAT);

      o = flat_orders(9); o[3] = 4; o[5] = 2; o[6] = 3;
      apply_stimulus(8'b0110_1000, '0, o, 1'b0);

      o = flat_orders(9); o[0] = 1; o[1] = 2; o[2] = 2;
      apply_stimulus(8'b0000_0111, '0, o, 1'b0);

      o = flat_orders(9); o[0] = 1; o[1] = 2; o[2] = 3;
      apply_stimulus(8'b0000_0111, 8'b0000_0011, o, 1'b0);
      apply_stimulus(8'b0000_0110, 8'b0000_0010, o, 1'b0);
      idle(MULT_LAT);

      o = flat_orders(1); o[1] = 2;
      apply_stimulus(8'b0000_0001, 8'b0000_0001, o, 1'b0);
      apply_stimulus(8'b0000_0001, 8'b0000_0001, o, 1'b0);
      apply_stimulus(8'b0000_0110, '0, o, 1'b0);
      apply_stimulus(8'b0000_0110, '0, o, 1'b0);
      apply_stimulus(8'b0000_0110, '0, o, 1'b0);
      idle(MULT_LAT);

      apply_stimulus(8'b0000_0001, 8'b0000_0001, flat_orders(1), 1'b0);
      apply_stimulus('1, '0, flat_orders(2), 1'b1);
      apply_stimulus('1, '0, flat_orders(2), 1'b1);
      hold_reset('1, flat_orders(2), 1'b1);
      apply_stimulus('1, '0, flat_orders(2), 1'b1);
      idle(2);

      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            hold_reset(N_RS'($urandom), rand_orders(), 1'b0);
         end else begin
            apply_stimulus(N_RS'($urandom & $urandom), N_RS'($urandom), rand_orders(),
                           ($urandom_range(0, 7) == 0));
         end
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clock);
         drain++;
      end
      @(posedge clock);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
